// File: rtl/clk_div_ctrl.sv
// Run-time fabric clock prescaler: ratio changes and stops are deferred to the
// end of a full scaled-clock period. Optional CLK_DIV_CTRL_PERIOD_CNT_EN adds period_cnt.
module clk_div_ctrl #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             scaled_clk,
  output logic             rise_tick,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             busy
);

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_en_q, pend_en_d;
  logic             sclk_q, sclk_d;
  logic             rise_q, rise_d;
  logic             rst_n_q;
  logic             accept;
  logic             wrap;
  logic             boundary;

  assign cfg_ready  = rst_n_q & ~pend_vld_q;
  assign accept     = cfg_valid & cfg_ready;
  assign wrap       = (state_q == RUN) && (cnt_q == div_q);
  // A boundary is the falling toggle, i.e. the end of a complete low+high period.
  assign boundary   = wrap & sclk_q;
  assign scaled_clk = sclk_q;
  assign rise_tick  = rise_q;
  assign busy       = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_vld_d = pend_vld_q;
    pend_en_d  = pend_en_q;
    pend_div_d = pend_div_q;
    sclk_d     = sclk_q;
    rise_d     = 1'b0;

    unique case (state_q)
      OFF: begin
        if (accept && cfg_en) begin
          state_d = RUN;
          div_d   = cfg_div;
          cnt_d   = '0;
          sclk_d  = 1'b0;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          rise_d = ~sclk_q;
          if (boundary && pend_vld_q) begin
            pend_vld_d = 1'b0;
            if (pend_en_q) begin
              div_d = pend_div_q;
            end else begin
              state_d = OFF;
              sclk_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
        // cfg_ready is low while a request is pending, so this never collides
        // with the pending-apply above.
        if (accept) begin
          pend_vld_d = 1'b1;
          pend_en_d  = cfg_en;
          pend_div_d = cfg_div;
        end
      end
      default: state_d = OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      div_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_en_q  <= 1'b0;
      pend_div_q <= '0;
      sclk_q     <= 1'b0;
      rise_q     <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_vld_q <= pend_vld_d;
      pend_en_q  <= pend_en_d;
      pend_div_q <= pend_div_d;
      sclk_q     <= sclk_d;
      rise_q     <= rise_d;
      rst_n_q    <= 1'b1;
    end
  end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] pcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (boundary) begin
      pcnt_q <= pcnt_q + 16'd1;
    end
  end

  assign period_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-position reference model pushes
// the expected per-cycle outputs, a negedge monitor pops and compares them.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_en;
  logic [7:0] cfg_div;
  logic       scaled_clk;
  logic       rise_tick;
  logic       busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  clk_div_ctrl #(.DIV_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_en     (cfg_en),
    .cfg_div    (cfg_div),
    .scaled_clk (scaled_clk),
    .rise_tick  (rise_tick),
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    .period_cnt (period_cnt),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] outs;  // {scaled_clk, rise_tick, busy, cfg_ready}
    int         pcnt;
    int         cyc;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: position within the current low+high period.
  bit m_run, m_pend, m_pend_en, m_rdy;
  int m_div, m_pos, m_pend_div, m_pcnt;

  task automatic model_step();
    exp_t e;
    bit   was_run;
    bit   acc;
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_pend_en = 0; m_rdy = 0;
      m_div = 0; m_pos = 0; m_pend_div = 0; m_pcnt = 0;
    end else begin
      acc     = cfg_valid & m_rdy & ~m_pend;
      was_run = m_run;
      if (m_run) begin
        m_pos++;
        if (m_pos == 2 * (m_div + 1)) begin
          m_pos  = 0;
          m_pcnt = (m_pcnt + 1) % 65536;
          if (m_pend) begin
            m_pend = 0;
            if (m_pend_en) m_div = m_pend_div;
            else           m_run = 0;
          end
        end
      end
      if (acc) begin
        if (!was_run) begin
          if (cfg_en) begin
            m_run = 1; m_div = int'(cfg_div); m_pos = 0;
          end
        end else begin
          m_pend = 1; m_pend_en = cfg_en; m_pend_div = int'(cfg_div);
        end
      end
      m_rdy = 1;
    end
    e.outs[3] = m_run && (m_pos >= m_div + 1);
    e.outs[2] = m_run && (m_pos == m_div + 1);
    e.outs[1] = m_run;
    e.outs[0] = m_rdy & ~m_pend;
    e.pcnt    = m_pcnt;
    e.cyc     = cycle;
    expq.push_back(e);
    cycle++;
  endtask

  task automatic cyc(input bit v, input bit en, input int d, input bit rn);
    cfg_valid = v;
    cfg_en    = en;
    cfg_div   = 8'(d);
    rst_n     = rn;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, $urandom_range(0, 255), 1);
  endtask

  // Bounded wait on the model's period position (only meaningful while running).
  task automatic wait_pos(input int target);
    for (int i = 0; i < 1200; i++) begin
      if (m_run && m_pos == target) break;
      idle(1);
    end
  endtask

  // Monitor: outputs are presented every cycle.
  initial begin
    exp_t e;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        act = {scaled_clk, rise_tick, busy, cfg_ready};
        checks++;
        if (act !== e.outs) begin
          errors++;
          $display("FAIL outs cyc=%0d {sclk,rise,busy,rdy} got=%b exp=%b", e.cyc, act, e.outs);
        end
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        checks++;
        if (period_cnt !== 16'(e.pcnt)) begin
          errors++;
          $display("FAIL period_cnt cyc=%0d got=%0d exp=%0d", e.cyc, period_cnt, e.pcnt);
        end
`endif
      end
    end
  end

  initial begin
    cfg_valid = 0; cfg_en = 0; cfg_div = '0; rst_n = 0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    idle(2);

    // div=3 start, ratio change mid-high phase
    cyc(1, 1, 3, 1);
    idle(20);
    wait_pos(m_div + 2);
    cyc(1, 1, 1, 1);
    idle(30);

    // stop during low phase
    wait_pos(1);
    cyc(1, 0, 0, 1);
    idle(20);

    // accept exactly on the boundary posedge
    cyc(1, 1, 2, 1);
    idle(8);
    wait_pos(2 * (m_div + 1) - 1);
    cyc(1, 1, 5, 1);
    idle(40);

    // div=0, then reset while scaled_clk is high
    cyc(1, 1, 0, 1);
    idle(20);
    wait_pos(1);
    cyc(0, 0, 0, 0);
    idle(3);

    // en=0 accepted in OFF is a no-op
    cyc(1, 0, 4, 1);
    idle(3);

    // valid held while not ready; payload must come from the accept cycle only
    cyc(1, 1, 2, 1);
    idle(2);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1 + (i % 4), 1);
    idle(30);

    // maximum divide
    cyc(1, 0, 0, 1);
    idle(20);
    cyc(1, 1, 255, 1);
    idle(1100);
    cyc(1, 0, 0, 1);
    idle(520);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit v, en, rn;
      int d;
      v  = ($urandom_range(0, 5) == 0);
      en = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 39) == 0) ? 255 : $urandom_range(0, 6);
      rn = ($urandom_range(0, 399) != 0);
      cyc(v, en, d, rn);
    end
    idle(4);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
